// File: rtl/agc_gain_ctrl.sv
// AGC gain controller: derives a level from the EMA accumulator, integrates the
// error against a target into a clamped Q2.16 gain, and applies it to the sample stream.
module agc_gain_ctrl #(
    parameter logic [17:0] GAIN_INIT  = 18'h10000,
    parameter logic [17:0] GAIN_MIN   = 18'h00400,
    parameter logic [17:0] GAIN_MAX   = 18'h3FFFF,
    parameter int          SETTLE_CNT = 16,
    parameter logic [26:0] LOCK_TOL   = 27'd4096,
    parameter int          LOCK_CNT   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [47:0] ema_data,
    input  logic        ema_valid,
    input  logic [26:0] target_level,
    input  logic [4:0]  step_shift,
    input  logic [15:0] sample_in,
    input  logic        sample_valid,
    output logic [15:0] sample_out,
    output logic        sample_valid_out,
    output logic [17:0] gain,
    output logic        locked,
    output logic        gain_at_limit,
    output logic [1:0]  state_dbg
);

    // Handshake: ema_valid and sample_valid are single-cycle qualifiers with no
    // ready; every asserted cycle is consumed. sample_valid_out qualifies
    // sample_out exactly two clocks after the matching sample_valid.

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        TRACK  = 2'd2
    } state_t;

    localparam int SW  = $clog2(SETTLE_CNT + 1);
    localparam int LCW = $clog2(LOCK_CNT + 1);

    localparam logic signed [29:0] MIN_EXT  = {12'b0, GAIN_MIN};
    localparam logic signed [29:0] MAX_EXT  = {12'b0, GAIN_MAX};
    localparam logic               INIT_LIM = (GAIN_INIT == GAIN_MIN) || (GAIN_INIT == GAIN_MAX);

    localparam logic signed [35:0] RND_HALF = 36'sd32768;
    localparam logic signed [35:0] SAT_HI   = 36'sd32767;
    localparam logic signed [35:0] SAT_LO   = -36'sd32768;

    state_t            state, state_nxt;
    logic [SW-1:0]     settle_cnt, settle_nxt;
    logic              upd_fire;

    logic [26:0]       level;
    logic signed [27:0] err_comb;
    logic signed [27:0] err_q;
    logic              upd_v1;

    logic signed [29:0] err_ext;
    logic signed [29:0] delta;
    logic signed [29:0] sum;
    logic [17:0]       gain_clamp;
    logic              clamp_lim;
    logic [27:0]       abs_err;
    logic              in_band;
    logic [LCW-1:0]    lock_cnt, lock_cnt_nxt;

    logic signed [34:0] s_ext, g_ext, prod_c, prod_q;
    logic              sv1;
    logic signed [35:0] rnd, shifted;
    logic [15:0]       sat_c;

    // Low accumulator bits lie below the level's resolution.
    logic unused_ema_lsbs;
    assign unused_ema_lsbs = ^ema_data[13:0];

    assign state_dbg = state;

    // Negative accumulator reads as silence; anything above the 27-bit window saturates.
    always_comb begin
        level = ema_data[40:14];
        if (ema_data[47]) begin
            level = '0;
        end else if (ema_data[46:41] != 6'd0) begin
            level = 27'h7FFFFFF;
        end
    end

    assign err_comb = $signed({1'b0, target_level}) - $signed({1'b0, level});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            settle_cnt <= '0;
        end else begin
            state      <= state_nxt;
            settle_cnt <= settle_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        settle_nxt = settle_cnt;
        upd_fire   = 1'b0;
        if (!enable) begin
            state_nxt  = IDLE;
            settle_nxt = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt  = SETTLE;
                    settle_nxt = '0;
                end
                SETTLE: begin
                    if (ema_valid) begin
                        if (settle_cnt == SW'(SETTLE_CNT - 1)) begin
                            state_nxt  = TRACK;
                            settle_nxt = '0;
                        end else begin
                            settle_nxt = settle_cnt + 1'b1;
                        end
                    end
                end
                TRACK: begin
                    upd_fire = ema_valid;
                end
                default: begin
                    state_nxt  = IDLE;
                    settle_nxt = '0;
                end
            endcase
        end
    end

    // Update cycle 1: capture the error of each accepted strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q  <= '0;
            upd_v1 <= 1'b0;
        end else begin
            upd_v1 <= upd_fire;
            if (upd_fire) begin
                err_q <= err_comb;
            end
        end
    end

    // Update cycle 2: integrate, clamp and track lock.
    always_comb begin
        err_ext    = {{2{err_q[27]}}, err_q};
        delta      = err_ext >>> step_shift;
        sum        = $signed({12'b0, gain}) + delta;
        gain_clamp = sum[17:0];
        if (sum < MIN_EXT) begin
            gain_clamp = GAIN_MIN;
        end else if (sum > MAX_EXT) begin
            gain_clamp = GAIN_MAX;
        end
        clamp_lim = (gain_clamp == GAIN_MIN) || (gain_clamp == GAIN_MAX);

        abs_err = err_q[27] ? 28'(-err_q) : 28'(err_q);
        in_band = abs_err < {1'b0, LOCK_TOL};
        lock_cnt_nxt = '0;
        if (in_band) begin
            lock_cnt_nxt = (lock_cnt == LCW'(LOCK_CNT)) ? lock_cnt : lock_cnt + 1'b1;
        end
    end

    // Dropping enable overrides any update landing in the same clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gain          <= GAIN_INIT;
            gain_at_limit <= 1'b0;
            lock_cnt      <= '0;
            locked        <= 1'b0;
        end else if (!enable) begin
            gain          <= GAIN_INIT;
            gain_at_limit <= INIT_LIM;
            lock_cnt      <= '0;
            locked        <= 1'b0;
        end else if (upd_v1) begin
            gain          <= gain_clamp;
            gain_at_limit <= clamp_lim;
            lock_cnt      <= lock_cnt_nxt;
            locked        <= (lock_cnt_nxt == LCW'(LOCK_CNT));
        end
    end

    // Sample path stage 1 sees the gain register before any same-cycle update.
    assign s_ext  = {{19{sample_in[15]}}, sample_in};
    assign g_ext  = {17'b0, gain};
    assign prod_c = s_ext * g_ext;

    always_comb begin
        rnd     = {prod_q[34], prod_q} + RND_HALF;
        shifted = rnd >>> 16;
        sat_c   = shifted[15:0];
        if (shifted > SAT_HI) begin
            sat_c = 16'h7FFF;
        end else if (shifted < SAT_LO) begin
            sat_c = 16'h8000;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q           <= '0;
            sv1              <= 1'b0;
            sample_out       <= '0;
            sample_valid_out <= 1'b0;
        end else begin
            sv1              <= sample_valid;
            sample_valid_out <= sv1;
            if (sample_valid) begin
                prod_q <= prod_c;
            end
            if (sv1) begin
                sample_out <= sat_c;
            end
        end
    end

endmodule

// File: tb/tb_agc_gain_ctrl.sv
// Directed bench for agc_gain_ctrl: sample outputs go through an expected-value
// queue checked by a monitor; gain/lock/state are checked at fixed clock offsets.
module tb_agc_gain_ctrl;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [47:0] ema_data;
    logic        ema_valid;
    logic [26:0] target_level;
    logic [4:0]  step_shift;
    logic [15:0] sample_in;
    logic        sample_valid;
    logic [15:0] sample_out;
    logic        sample_valid_out;
    logic [17:0] gain;
    logic        locked;
    logic        gain_at_limit;
    logic [1:0]  state_dbg;

    int n_checks = 0;
    int n_errors = 0;
    logic signed [15:0] exp_q[$];
    logic signed [15:0] exp_v;
    logic mon_en = 1'b1;

    localparam logic [26:0] LOCK_T = 27'h0100000;

    agc_gain_ctrl dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .enable           (enable),
        .ema_data         (ema_data),
        .ema_valid        (ema_valid),
        .target_level     (target_level),
        .step_shift       (step_shift),
        .sample_in        (sample_in),
        .sample_valid     (sample_valid),
        .sample_out       (sample_out),
        .sample_valid_out (sample_valid_out),
        .gain             (gain),
        .locked           (locked),
        .gain_at_limit    (gain_at_limit),
        .state_dbg        (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic logic [47:0] mk_ema(input logic [26:0] lvl);
        return {7'b0, lvl, 14'b0};
    endfunction

    // driver tasks: called at posedge+1, return at posedge+1
    task automatic send_sample(input logic signed [15:0] s, input logic signed [15:0] e);
        sample_in    = s;
        sample_valid = 1'b1;
        exp_q.push_back(e);
        @(posedge clk); #1;
        sample_valid = 1'b0;
    endtask

    task automatic ema_strobe(input logic [47:0] d);
        ema_data  = d;
        ema_valid = 1'b1;
        @(posedge clk); #1;
        ema_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (mon_en && rst_n && sample_valid_out) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL sample_unexpected: got %0d, required no output", $signed(sample_out));
            end else begin
                exp_v = exp_q.pop_front();
                check("sample_out", int'($signed(sample_out)), int'(exp_v));
            end
        end
    end

    initial begin
        rst_n        = 1'b0;
        enable       = 1'b0;
        ema_data     = '0;
        ema_valid    = 1'b0;
        target_level = '0;
        step_shift   = '0;
        sample_in    = '0;
        sample_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_gain", int'(gain), 32'h10000);
        check("rst_sample_out", int'(sample_out), 0);
        check("rst_svo", int'(sample_valid_out), 0);
        check("rst_locked", int'(locked), 0);
        check("rst_limit", int'(gain_at_limit), 0);
        check("rst_state", int'(state_dbg), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // passthrough at unity gain, including rounding of a small value
        send_sample(16'sd1000, 16'sd1000);
        send_sample(-16'sd1000, -16'sd1000);
        send_sample(16'sd32767, 16'sd32767);
        send_sample(16'sd3, 16'sd3);
        repeat (3) @(posedge clk);
        #1;
        check("pass_gain", int'(gain), 32'h10000);

        // settle: 16 strobes ignored, 17th steps gain by 0x20000>>>4
        enable       = 1'b1;
        target_level = 27'h0040000;
        step_shift   = 5'd4;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 1; i <= 16; i++) begin
            ema_strobe(mk_ema(27'h0020000));
            if (i == 15) check("settle_state15", int'(state_dbg), 1);
        end
        check("settle_gain", int'(gain), 32'h10000);
        check("settle_state16", int'(state_dbg), 2);

        ema_data  = mk_ema(27'h0020000);
        ema_valid = 1'b1;
        @(posedge clk); #1;
        ema_valid = 1'b0;
        check("step_gain_1clk", int'(gain), 32'h10000);
        sample_in    = 16'sd1000;
        sample_valid = 1'b1;
        exp_q.push_back(16'sd1000);      // same cycle as the update: old gain
        @(posedge clk); #1;
        check("step_gain_2clk", int'(gain), 32'h12000);
        exp_q.push_back(16'sd1125);      // 1000 * 1.125
        @(posedge clk); #1;
        sample_valid = 1'b0;

        // clamp high
        target_level = 27'h7FFFFFF;
        step_shift   = 5'd0;
        ema_strobe(mk_ema(27'h0));
        check("max_gain", int'(gain), 32'h3FFFF);
        check("max_limit", int'(gain_at_limit), 1);
        ema_strobe(mk_ema(27'h0));
        check("max_hold", int'(gain), 32'h3FFFF);
        send_sample(16'sd16000, 16'sd32767);
        send_sample(-16'sd16000, -16'sd32768);
        send_sample(16'sd3, 16'sd12);

        // clamp low with a saturating accumulator (level = max)
        target_level = 27'h0;
        ema_strobe({7'b0000001, 41'b0});
        check("min_gain", int'(gain), 32'h00400);
        check("min_limit", int'(gain_at_limit), 1);
        send_sample(16'sd16000, 16'sd250);

        // negative accumulator reads as level 0
        target_level = 27'h0040000;
        step_shift   = 5'd4;
        ema_strobe(48'h8000_0000_0000);
        check("neg_gain", int'(gain), 32'h04400);
        check("neg_limit", int'(gain_at_limit), 0);

        // lock after 8 in-band updates, drop on one out-of-band update
        target_level = LOCK_T;
        step_shift   = 5'd20;
        for (int i = 0; i < 8; i++) begin
            ema_strobe(mk_ema((i % 2 == 0) ? LOCK_T - 27'd100 : LOCK_T - 27'd50));
            if (i == 6) check("lock_after7", int'(locked), 0);
        end
        check("lock_after8", int'(locked), 1);
        ema_strobe(mk_ema(LOCK_T - 27'd5000));
        check("lock_drop", int'(locked), 0);
        check("lock_gain", int'(gain), 32'h04400);

        // back-to-back strobes are each applied
        target_level = 27'h0040000;
        step_shift   = 5'd8;
        ema_data     = mk_ema(27'h0020000);
        ema_valid    = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        ema_valid = 1'b0;
        check("b2b_first", int'(gain), 32'h04600);
        @(posedge clk); #1;
        check("b2b_second", int'(gain), 32'h04800);

        // enable falls on the update cycle: reload wins
        ema_valid = 1'b1;
        @(posedge clk); #1;
        ema_valid = 1'b0;
        enable    = 1'b0;
        @(posedge clk); #1;
        check("dis_gain", int'(gain), 32'h10000);
        check("dis_state", int'(state_dbg), 0);
        check("dis_locked", int'(locked), 0);
        @(posedge clk); #1;
        check("dis_gain_hold", int'(gain), 32'h10000);

        // asynchronous reset with samples in flight
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst_queue", exp_q.size(), 0);
        mon_en       = 1'b0;
        enable       = 1'b1;
        sample_in    = 16'sd200;
        sample_valid = 1'b1;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_sample_out", int'(sample_out), 0);
        check("arst_svo", int'(sample_valid_out), 0);
        check("arst_gain", int'(gain), 32'h10000);
        check("arst_state", int'(state_dbg), 0);
        sample_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        exp_q.delete();
        mon_en = 1'b1;
        send_sample(16'sd500, 16'sd500);
        check("rel_svo_1clk", int'(sample_valid_out), 0);
        @(posedge clk); #1;
        check("rel_svo_2clk", int'(sample_valid_out), 1);

        repeat (4) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
